// File: rtl/rca_sweep_checker.sv
// Exhaustive on-board self-test for an n-bit ripple-carry adder: drives every {Cin,A,B},
// checks the returned sum/carry, counts mismatches and latches the first failure.
// Optional build macro RCA_CHK_HALT_ON_FAIL_EN stops the sweep at the first mismatch.
module rca_sweep_checker #(
   parameter int SIZE   = 2,
   parameter int SETTLE = 2,
   parameter int ERRW   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [SIZE-1:0] PortA_nbit,
   output logic [SIZE-1:0] PortB_nbit,
   output logic            PortCin_nbit,
   input  logic [SIZE-1:0] PortS_nbit,
   input  logic            PortCout_nbit,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [ERRW-1:0] err_count,
   output logic [SIZE-1:0] fail_a,
   output logic [SIZE-1:0] fail_b,
   output logic            fail_cin,
   output logic [SIZE-1:0] fail_s,
   output logic            fail_cout
);

   localparam int VW = 2 * SIZE + 1;
   localparam int CW = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [VW-1:0]   vec_q;
   logic [VW-1:0]   vec_d;
   logic [ERRW-1:0] errCount_q;
   logic [ERRW-1:0] errCount_d;
   logic [SIZE-1:0] failA_q, failB_q, failS_q;
   logic            failCin_q, failCout_q;
   logic            busy_q, done_q, pass_q;

   logic [SIZE:0]   expected;
   logic            mismatch;
   logic            lastVec;

   // Vector layout {Cin,A,B} makes a plain increment walk Cin outer, A middle, B inner.
   always_comb begin
      expected   = {1'b0, vec_q[2*SIZE-1:SIZE]} + {1'b0, vec_q[SIZE-1:0]}
                 + {{SIZE{1'b0}}, vec_q[VW-1]};
      mismatch   = ({PortCout_nbit, PortS_nbit} != expected);
      lastVec    = (vec_q == {VW{1'b1}});
      vec_d      = vec_q + VW'(1);
      errCount_d = errCount_q;
      if (mismatch && (errCount_q != {ERRW{1'b1}}))
         errCount_d = errCount_q + ERRW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         vec_q      <= '0;
         errCount_q <= '0;
         failA_q    <= '0;
         failB_q    <= '0;
         failCin_q  <= 1'b0;
         failS_q    <= '0;
         failCout_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q    <= S_SETTLE;
                  cnt_q      <= '0;
                  vec_q      <= '0;
                  errCount_q <= '0;
                  failA_q    <= '0;
                  failB_q    <= '0;
                  failCin_q  <= 1'b0;
                  failS_q    <= '0;
                  failCout_q <= 1'b0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  pass_q     <= 1'b0;
               end
            end
            S_SETTLE: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(SETTLE - 1))
                  state_q <= S_CHECK;
            end
            S_CHECK: begin
               errCount_q <= errCount_d;
               // errCount_q is zero only until the first mismatch has been recorded.
               if (mismatch && (errCount_q == '0)) begin
                  failA_q    <= vec_q[2*SIZE-1:SIZE];
                  failB_q    <= vec_q[SIZE-1:0];
                  failCin_q  <= vec_q[VW-1];
                  failS_q    <= PortS_nbit;
                  failCout_q <= PortCout_nbit;
               end
`ifdef RCA_CHK_HALT_ON_FAIL_EN
               if (lastVec || mismatch) begin
`else
               if (lastVec) begin
`endif
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (errCount_d == '0);
               end else begin
                  vec_q   <= vec_d;
                  cnt_q   <= '0;
                  state_q <= S_SETTLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign PortA_nbit   = vec_q[2*SIZE-1:SIZE];
   assign PortB_nbit   = vec_q[SIZE-1:0];
   assign PortCin_nbit = vec_q[VW-1];
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign err_count    = errCount_q;
   assign fail_a       = failA_q;
   assign fail_b       = failB_q;
   assign fail_cin     = failCin_q;
   assign fail_s       = failS_q;
   assign fail_cout    = failCout_q;

endmodule

// File: tb/tb_rca_sweep_checker.sv
// Bench for rca_sweep_checker: a behavioural adder with injectable faults feeds two checkers
// (default ERRW and ERRW=4 for saturation); table-driven sweeps plus reset/restart sequences.
module tb_rca_sweep_checker;

   localparam int SIZE = 2;

   logic clk = 1'b0;
   logic rst;
   logic start;
   int   faultMode;

   logic [SIZE-1:0] pa, pb, ps, pa4, pb4, ps4;
   logic            pcin, pcout, pcin4, pcout4;
   logic            busy, done, pass, busy4, done4, pass4;
   logic [15:0]     errCount;
   logic [3:0]      errCount4;
   logic [SIZE-1:0] failA, failB, failS, failA4, failB4, failS4;
   logic            failCin, failCout, failCin4, failCout4;

   int testsRun  = 0;
   int testsFail = 0;

   always #5 clk = ~clk;

   // Fault 0: good adder, 1: carry-out stuck at 0, 2: sum bit 0 inverted.
   function automatic logic [SIZE:0] adderModel(int f, logic [SIZE-1:0] a, logic [SIZE-1:0] b,
                                                logic c);
      logic [SIZE:0] r;
      r = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, c};
      if (f == 1) r[SIZE] = 1'b0;
      if (f == 2) r[0] = ~r[0];
      return r;
   endfunction

   assign {pcout, ps}   = adderModel(faultMode, pa, pb, pcin);
   assign {pcout4, ps4} = adderModel(faultMode, pa4, pb4, pcin4);

   rca_sweep_checker #(.SIZE(SIZE), .SETTLE(2), .ERRW(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .PortA_nbit(pa), .PortB_nbit(pb), .PortCin_nbit(pcin),
      .PortS_nbit(ps), .PortCout_nbit(pcout),
      .busy(busy), .done(done), .pass(pass), .err_count(errCount),
      .fail_a(failA), .fail_b(failB), .fail_cin(failCin),
      .fail_s(failS), .fail_cout(failCout)
   );

   rca_sweep_checker #(.SIZE(SIZE), .SETTLE(2), .ERRW(4)) dut4 (
      .clk(clk), .rst(rst), .start(start),
      .PortA_nbit(pa4), .PortB_nbit(pb4), .PortCin_nbit(pcin4),
      .PortS_nbit(ps4), .PortCout_nbit(pcout4),
      .busy(busy4), .done(done4), .pass(pass4), .err_count(errCount4),
      .fail_a(failA4), .fail_b(failB4), .fail_cin(failCin4),
      .fail_s(failS4), .fail_cout(failCout4)
   );

   typedef struct {
      int fault;
      int cycles;
      int err;
      int err4;
      int pass;
      int fa, fb, fcin, fs, fcout;
      int pa, pb, pcin;
   } vec_t;

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual !== expected) begin
         testsFail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Pulses start across one rising edge, then counts edges until done (bounded).
   task automatic applyStimulus(input int stopAt, output int cycles);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cycles = 1;
      while (cycles < 500) begin
         if (cycles == stopAt) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cycles++;
         end else begin
            @(negedge clk);
            cycles++;
         end
         if (done) break;
      end
      // The loop counts negedges; done after edge N is first seen at the negedge after it.
      cycles = cycles - 1;
   endtask

   vec_t tbl[3];
   int   cyc;

   initial begin
`ifdef RCA_CHK_HALT_ON_FAIL_EN
      tbl[0] = '{1, 24, 1, 1, 0, 1, 3, 0, 0, 0, 1, 3, 0};
      tbl[1] = '{2, 3, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
`else
      tbl[0] = '{1, 96, 16, 15, 0, 1, 3, 0, 0, 0, 3, 3, 1};
      tbl[1] = '{2, 96, 32, 15, 0, 0, 0, 0, 1, 0, 3, 3, 1};
`endif
      tbl[2] = '{0, 96, 0, 0, 1, 0, 0, 0, 0, 0, 3, 3, 1};

      rst = 1'b1;
      start = 1'b0;
      faultMode = 0;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset done", int'(done), 0);
      checkOutput("reset pass", int'(pass), 0);
      checkOutput("reset err", int'(errCount), 0);
      checkOutput("reset portA", int'(pa), 0);
      checkOutput("reset failS", int'(failS), 0);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         faultMode = tbl[i].fault;
         applyStimulus(-1, cyc);
         checkOutput($sformatf("v%0d cycles", i), cyc, tbl[i].cycles);
         checkOutput($sformatf("v%0d busy", i), int'(busy), 0);
         checkOutput($sformatf("v%0d err", i), int'(errCount), tbl[i].err);
         checkOutput($sformatf("v%0d err4", i), int'(errCount4), tbl[i].err4);
         checkOutput($sformatf("v%0d pass", i), int'(pass), tbl[i].pass);
         checkOutput($sformatf("v%0d pass4", i), int'(pass4), tbl[i].pass);
         checkOutput($sformatf("v%0d fail_a", i), int'(failA), tbl[i].fa);
         checkOutput($sformatf("v%0d fail_b", i), int'(failB), tbl[i].fb);
         checkOutput($sformatf("v%0d fail_cin", i), int'(failCin), tbl[i].fcin);
         checkOutput($sformatf("v%0d fail_s", i), int'(failS), tbl[i].fs);
         checkOutput($sformatf("v%0d fail_cout", i), int'(failCout), tbl[i].fcout);
         checkOutput($sformatf("v%0d portA", i), int'(pa), tbl[i].pa);
         checkOutput($sformatf("v%0d portB", i), int'(pb), tbl[i].pb);
         checkOutput($sformatf("v%0d portCin", i), int'(pcin), tbl[i].pcin);
         repeat (2) @(negedge clk);
         checkOutput($sformatf("v%0d done held", i), int'(done), 1);
      end

      // Reset in the middle of a sweep clears everything at that edge.
      faultMode = 1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (39) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst busy", int'(busy), 0);
      checkOutput("midrst done", int'(done), 0);
      checkOutput("midrst err", int'(errCount), 0);
      checkOutput("midrst portA", int'(pa), 0);
      checkOutput("midrst portB", int'(pb), 0);
      checkOutput("midrst failA", int'(failA), 0);
      rst = 1'b0;
      faultMode = 0;
      applyStimulus(-1, cyc);
      checkOutput("postrst cycles", cyc, 96);
      checkOutput("postrst pass", int'(pass), 1);

      // A start pulse during the sweep must not restart it.
      applyStimulus(10, cyc);
      checkOutput("midstart cycles", cyc, 96);
      checkOutput("midstart pass", int'(pass), 1);
      checkOutput("midstart err", int'(errCount), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
